opera_bus_decoder: RTL and testbench
====================================

OPERA_BUS_DECODER -- requirements
Module: opera_bus_decoder

Interface
REQ-001 Parameter NUM_SLAVES, default 4: slave channel count, legal range 1..8.
REQ-002 Parameter SLAVE_BASE, default {32'h03400000,32'h03300000,32'h03206100,32'h00000000}: packed NUM_SLAVES x 32 base addresses, index 0 in the LSBs.
REQ-003 Parameter SLAVE_MASK, default {32'hFFFF0000,32'hFFFF0000,32'hFFFFF7FF,32'h00000000}: packed NUM_SLAVES x 32 compare masks.
REQ-004 Parameter DEFAULT_DATA, default 32'hBADACCE5: read data for unmatched or timed-out cycles.
REQ-005 Parameter TIMEOUT_CYCLES, default 255: maximum wait for a slave ack, legal range 1..65535.
REQ-006 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-007 i_reset  in  1  reset, synchronous, active-high.
REQ-008 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  master Wishbone classic controls.
REQ-009 i_wb_adr, i_wb_dat  in  32 each  master address, write data.
REQ-010 i_wb_sel  in  4  master byte lanes.
REQ-011 o_wb_dat  out  32  registered read data to master.
REQ-012 o_wb_ack, o_wb_err  out  1 each  master termination.
REQ-013 o_s_stb  out  NUM_SLAVES  one-hot slave strobe.
REQ-014 o_s_we, o_s_adr, o_s_dat, o_s_sel  out  1/32/32/4  registered copies broadcast to all slaves.
REQ-015 i_s_dat  in  NUM_SLAVES x 32  slave read data; i_s_ack  in  NUM_SLAVES  slave acks.

Function
REQ-016 Slave k SHALL match when (i_wb_adr & SLAVE_MASK[k]) == (SLAVE_BASE[k] & SLAVE_MASK[k]); the lowest matching index wins; mask 0 gives a catch-all.
REQ-017 FSM states IDLE, ACTIVE, LOCAL, RESP; encoding from the shared package.
REQ-018 IDLE: on i_wb_cyc & i_wb_stb, capture adr/dat/sel/we into o_s_*; go to ACTIVE with o_s_stb one-hot for the winner, or to LOCAL if no slave matches.
REQ-019 ACTIVE: hold o_s_stb; when the selected i_s_ack is 1, latch that slave's i_s_dat into o_wb_dat and go to RESP; acks from unselected slaves are ignored.
REQ-020 LOCAL: load DEFAULT_DATA into o_wb_dat and go to RESP after exactly one cycle, with no slave strobed.
REQ-021 RESP: o_wb_ack=1 (or o_wb_err per REQ-027) for exactly one cycle; o_s_stb=0; then IDLE.
REQ-022 Latency: request in IDLE at cycle 0, o_s_stb at cycle 1, slave ack at cycle n>=1, master ack at cycle n+1; an unmatched access acks at cycle 2.
REQ-023 Abort: i_wb_cyc=0 in ACTIVE or LOCAL clears o_s_stb next edge, returns to IDLE, and gives no ack or err; abort wins over a simultaneous slave ack.
REQ-024 Captured address, data and select SHALL be held stable on o_s_* from ACTIVE entry until RESP exit, regardless of master changes.
REQ-025 o_wb_ack and o_wb_err SHALL never both be 1; at most one o_s_stb bit SHALL be 1.

Reset
REQ-026 i_reset=1 at any edge forces IDLE, o_s_stb=0, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_s_adr=0, o_s_dat=0, o_s_sel=0, o_s_we=0 and timer=0, including mid-transfer; no ack is produced for an interrupted cycle.

Configuration
REQ-027 With OPERA_BUS_TIMEOUT_EN defined: a 16-bit counter clears on ACTIVE entry and increments each ACTIVE cycle; at TIMEOUT_CYCLES without an ack, o_wb_dat=DEFAULT_DATA, o_s_stb drops, and RESP asserts o_wb_err instead of o_wb_ack.
REQ-028 Without OPERA_BUS_TIMEOUT_EN: no counter exists, ACTIVE waits indefinitely, and o_wb_err is tied 0.

Structure
REQ-029 Package opera_bus_pkg SHALL hold the state enum, the 32-bit address/data width constants and the MAX_SLAVES=8 constant.
REQ-030 Sub-module opera_addr_match SHALL be purely combinational: address plus base/mask arrays in, one-hot winner plus hit flag out.

Verification
REQ-031 Read 0x03300004, slave1 ack at cycle 3 with 0x12345678 -> o_s_stb=4'b0010 at cycles 1-3, o_wb_ack and o_wb_dat=0x12345678 at cycle 4.
REQ-032 Write 0x03400040 data 0xA5A5A5A5 sel 4'b0011 -> slave0 sees those exact values on o_s_* with o_s_we=1; single-cycle ack follows its ack.
REQ-033 With the catch-all removed (SLAVE_MASK[3]=0xFFFFFFFF), read 0x00000000 -> no strobe, o_wb_ack at cycle 2 with 0xBADACCE5.
REQ-034 Overlap: 0x03206100 matches slave2 and slave3 -> only o_s_stb[2] asserted.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> o_wb_err pulse at cycle 6 with o_wb_dat=0xBADACCE5; no o_wb_ack.
REQ-036 i_wb_cyc drops at cycle 2 coinciding with a slave ack -> no ack or err, IDLE at cycle 3; reset asserted in ACTIVE -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/opera_bus_pkg.sv
// Shared definitions for the opera Wishbone bus decoder: bus widths, slave limit
// and the decoder FSM state encoding.
package opera_bus_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEL_W      = DATA_W / 8;
  localparam int unsigned MAX_SLAVES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LOCAL  = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/opera_addr_match.sv
// Combinational slave address decode: returns a one-hot winner (lowest matching
// index) and a hit flag. A zero mask makes that slave a catch-all.
module opera_addr_match
  import opera_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [NUM_SLAVES*ADDR_W-1:0] base_i,
  input  logic [NUM_SLAVES*ADDR_W-1:0] mask_i,
  output logic [NUM_SLAVES-1:0]        onehot_o,
  output logic                         hit_o
);

  // Walk from the highest index down so the lowest matching slave is written last.
  always_comb begin
    onehot_o = '0;
    for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
      if (((addr_i ^ base_i[k*ADDR_W +: ADDR_W]) & mask_i[k*ADDR_W +: ADDR_W]) == '0) begin
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

  assign hit_o = |onehot_o;

endmodule

// File: rtl/opera_bus_decoder.sv
// Wishbone classic 1-to-N bus decoder with registered slave-side copies.
// Define OPERA_BUS_TIMEOUT_EN to enable the slave-ack timeout and o_wb_err.
module opera_bus_decoder
  import opera_bus_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 4,
  // Literals are written highest index first so slave 0 sits in the LSBs.
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h00000000, 32'h03206100,
                                                        32'h03300000, 32'h03400000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {32'h00000000, 32'hFFFFF7FF,
                                                        32'hFFFF0000, 32'hFFFF0000},
  parameter logic [31:0]              DEFAULT_DATA   = 32'hBADACCE5,
  parameter int unsigned              TIMEOUT_CYCLES = 255
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [ADDR_W-1:0]            i_wb_adr,
  input  logic [DATA_W-1:0]            i_wb_dat,
  input  logic [SEL_W-1:0]             i_wb_sel,
  output logic [DATA_W-1:0]            o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  output logic [NUM_SLAVES-1:0]        o_s_stb,
  output logic                         o_s_we,
  output logic [ADDR_W-1:0]            o_s_adr,
  output logic [DATA_W-1:0]            o_s_dat,
  output logic [SEL_W-1:0]             o_s_sel,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_dat,
  input  logic [NUM_SLAVES-1:0]        i_s_ack
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("opera_bus_decoder: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   stb_q, stb_d;
  logic [ADDR_W-1:0]       adr_q, adr_d;
  logic [DATA_W-1:0]       wdat_q, wdat_d;
  logic [DATA_W-1:0]       rdat_q, rdat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic [NUM_SLAVES-1:0]   matchOneHot;
  logic                    matchHit;
  logic                    selAck;
  logic [DATA_W-1:0]       selData;
  logic                    timeout;

  opera_addr_match #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_match (
    .addr_i   (i_wb_adr),
    .base_i   (SLAVE_BASE),
    .mask_i   (SLAVE_MASK),
    .onehot_o (matchOneHot),
    .hit_o    (matchHit)
  );

  // Only the currently strobed slave may terminate the cycle.
  assign selAck = |(i_s_ack & stb_q);

  always_comb begin
    selData = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (stb_q[k]) selData = i_s_dat[k*DATA_W +: DATA_W];
    end
  end

`ifdef OPERA_BUS_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;

  // Zero outside ACTIVE, so it starts from zero on every ACTIVE entry.
  assign timer_d = (state_q == ACTIVE) ? timer_q + 16'd1 : 16'd0;
  assign timeout = (timer_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_reset) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          adr_d  = i_wb_adr;
          wdat_d = i_wb_dat;
          sel_d  = i_wb_sel;
          we_d   = i_wb_we;
          if (matchHit) begin
            stb_d   = matchOneHot;
            state_d = ACTIVE;
          end else begin
            state_d = LOCAL;
          end
        end
      end
      // Abort has priority over ack, ack over timeout.
      ACTIVE: begin
        if (!i_wb_cyc) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (selAck) begin
          rdat_d  = selData;
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          rdat_d  = DEFAULT_DATA;
          stb_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      LOCAL: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else begin
          rdat_d  = DEFAULT_DATA;
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      stb_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign o_wb_dat = rdat_q;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_s_stb  = stb_q;
  assign o_s_we   = we_q;
  assign o_s_adr  = adr_q;
  assign o_s_dat  = wdat_q;
  assign o_s_sel  = sel_q;

endmodule

// File: tb/tb_opera_bus_decoder.sv
// Randomized self-checking bench for opera_bus_decoder; the transaction-level
// reference model honours OPERA_BUS_TIMEOUT_EN the same way the build does.
`timescale 1ns/1ps
module tb_opera_bus_decoder;

  localparam int NS  = 4;
  localparam int TMO = 4;
  // Slave 3 overlaps slave 2 but is no catch-all, so unmatched addresses exist.
  localparam logic [NS*32-1:0] TB_BASE = {32'h03206000, 32'h03206100, 32'h03300000, 32'h03400000};
  localparam logic [NS*32-1:0] TB_MASK = {32'hFFFFF000, 32'hFFFFF7FF, 32'hFFFF0000, 32'hFFFF0000};
  localparam logic [31:0]      DEF     = 32'hBADACCE5;
`ifdef OPERA_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk, rst;
  logic           cyc, stb, we;
  logic [31:0]    adr, dat;
  logic [3:0]     sel;
  logic [31:0]    wbDat;
  logic           wbAck, wbErr;
  logic [NS-1:0]  sStb;
  logic           sWe;
  logic [31:0]    sAdr, sDat;
  logic [3:0]     sSel;
  logic [NS*32-1:0] sDatIn;
  logic [NS-1:0]  sAck;

  int total = 0;
  int bad   = 0;

  opera_bus_decoder #(
    .NUM_SLAVES(NS), .SLAVE_BASE(TB_BASE), .SLAVE_MASK(TB_MASK),
    .DEFAULT_DATA(DEF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .o_wb_dat(wbDat), .o_wb_ack(wbAck), .o_wb_err(wbErr),
    .o_s_stb(sStb), .o_s_we(sWe), .o_s_adr(sAdr), .o_s_dat(sDat), .o_s_sel(sSel),
    .i_s_dat(sDatIn), .i_s_ack(sAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tbBase(input int k);
    return TB_BASE[k*32 +: 32];
  endfunction

  function automatic logic [31:0] tbMask(input int k);
    return TB_MASK[k*32 +: 32];
  endfunction

  function automatic int winnerOf(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & tbMask(k)) == (tbBase(k) & tbMask(k))) return k;
    return -1;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_stb"}, 32'(sStb), 32'd0);
    checkOutput({tag, "_ack"}, 32'(wbAck), 32'd0);
    checkOutput({tag, "_err"}, 32'(wbErr), 32'd0);
  endtask

  // One master transaction: ackAt = cycle the selected slave acks, abortAt = cycle
  // the master drops cyc (0 = never). Cycle 0 is the cycle the request is presented.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic w, input int ackAt, input int abortAt,
                               input logic [31:0] selData);
    int win, endC;
    bit isAbort, isErr;
    logic [NS-1:0] expStb, one;
    one = 1;
    win = winnerOf(a);
    isErr = 1'b0;
    isAbort = 1'b0;
    if (win < 0) begin
      endC = 1;
      expStb = '0;
      isAbort = (abortAt == 1);
    end else begin
      expStb = one << win;
      endC = ackAt;
      if (TMO_EN && ackAt > TMO + 1) begin
        endC = TMO + 1;
        isErr = 1'b1;
      end
      if (abortAt >= 1 && abortAt <= endC) begin
        endC = abortAt;
        isAbort = 1'b1;
        isErr = 1'b0;
      end
    end
    cyc = 1'b1; stb = 1'b1; adr = a; dat = d; sel = s; we = w;
    sAck = '0;
    for (int c = 1; c <= endC + 1; c++) begin
      nextCycle();
      checkOutput("stb", 32'(sStb), (c <= endC) ? 32'(expStb) : 32'd0);
      checkOutput("ack", 32'(wbAck), 32'(c == endC + 1 && !isAbort && !isErr));
      checkOutput("err", 32'(wbErr), 32'(c == endC + 1 && !isAbort && isErr));
      if (c <= endC || !isAbort) begin
        checkOutput("s_adr", sAdr, a);
        checkOutput("s_dat", sDat, d);
        checkOutput("s_sel", 32'(sSel), 32'(s));
        checkOutput("s_we", 32'(sWe), 32'(w));
      end
      if (c == endC + 1 && !isAbort)
        checkOutput("rdata", wbDat, (win < 0 || isErr) ? DEF : selData);
      adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      for (int k = 0; k < NS; k++) sDatIn[k*32 +: 32] = $urandom;
      if (win >= 0) sDatIn[win*32 +: 32] = selData;
      sAck = NS'($urandom) & ~expStb;
      if (win >= 0 && c == ackAt) sAck[win] = 1'b1;
      if (c == abortAt) begin cyc = 1'b0; stb = 1'b0; end
      if (c == endC + 1) begin cyc = 1'b0; stb = 1'b0; sAck = '0; end
    end
    for (int g = 0; g <= int'($urandom_range(0, 2)); g++) begin
      nextCycle();
      checkQuiet("idle");
    end
  endtask

  task automatic resetMidTransfer();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'h03400010; dat = 32'h5A5A1234; sAck = '0;
    nextCycle();
    checkOutput("rst_pre_stb", 32'(sStb), 32'h1);
    nextCycle();
    rst = 1'b1;
    sAck[0] = 1'b1;
    nextCycle();
    checkQuiet("rst_mid");
    checkOutput("rst_mid_rdat", wbDat, 32'd0);
    checkOutput("rst_mid_adr", sAdr, 32'd0);
    checkOutput("rst_mid_dat", sDat, 32'd0);
    checkOutput("rst_mid_sel", 32'(sSel), 32'd0);
    checkOutput("rst_mid_we", 32'(sWe), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; sAck = '0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkQuiet("rst_after");
    end
  endtask

  initial begin
    int r;
    logic [31:0] a;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0; sDatIn = '0; sAck = '0;
    nextCycle();
    nextCycle();
    checkQuiet("reset");
    checkOutput("reset_rdat", wbDat, 32'd0);
    checkOutput("reset_adr", sAdr, 32'd0);
    checkOutput("reset_dat", sDat, 32'd0);
    checkOutput("reset_sel", 32'(sSel), 32'd0);
    checkOutput("reset_we", 32'(sWe), 32'd0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] directed transactions");
    applyStimulus(32'h03300004, 32'h0, 4'hF, 1'b0, 3, 0, 32'h12345678);
    applyStimulus(32'h03400040, 32'hA5A5A5A5, 4'b0011, 1'b1, 1, 0, 32'h0BADF00D);
    applyStimulus(32'h00000000, 32'h11111111, 4'hF, 1'b0, 1, 0, 32'h0);
    applyStimulus(32'h03206100, 32'h22222222, 4'hF, 1'b0, 2, 0, 32'hCAFE0002);
    applyStimulus(32'h03206010, 32'h33333333, 4'h1, 1'b0, 2, 0, 32'hCAFE0003);
    applyStimulus(32'h03300008, 32'h44444444, 4'hF, 1'b0, 20, 0, 32'hDEAD0020);
    applyStimulus(32'h03300010, 32'h55555555, 4'hF, 1'b0, 2, 2, 32'h66666666);
    applyStimulus(32'h12345678, 32'h77777777, 4'hF, 1'b0, 1, 1, 32'h0);
    resetMidTransfer();

    $display("[TB] random transactions");
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 4));
      if (r < NS) a = (tbBase(r) & tbMask(r)) | ($urandom & ~tbMask(r));
      else        a = $urandom;
      applyStimulus(a, $urandom, 4'($urandom), 1'($urandom),
                    int'($urandom_range(1, 8)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0,
                    $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
